audio_level_meter: RTL and testbench

- Multi-channel audio level meter that turns signed PCM samples from the codec path into per-channel bar heights, plus peak-hold markers for the LED-matrix display.
- Replaces the ad-hoc single-channel abs/shift height logic in the top level.
- Adds the following, all parametrised:
  - Channel count, sample width and height width.
  - Offset floor and saturation.
  - Block-averaging mode.
  - Peak-hold with timed decay.
- Sits on the 48 MHz audio clock between the codec/filter outputs and the display driver.

---
 rtl/audio_level_meter.sv | 174 +++++++++++++++++
 tb/tb_audio_level_meter.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_level_meter.sv
// Multi-channel audio level meter: signed PCM samples in, per-channel bar heights
// and peak-hold markers out. Supports instantaneous and block-average modes.
module audio_level_meter #(
  parameter int CHANNELS  = 2,
  parameter int SAMPLE_W  = 16,
  parameter int HEIGHT_W  = 4,
  parameter int OFFSET    = 0,
  parameter int AVG_LOG2  = 4,
  parameter int HOLD_CNT  = 24000,
  parameter int DECAY_CNT = 1200
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sample_valid,
  input  logic [CHANNELS*SAMPLE_W-1:0] sample_in,
  input  logic [3:0]                   shift,
  input  logic                         mode,
  output logic [CHANNELS*HEIGHT_W-1:0] height,
  output logic [CHANNELS*HEIGHT_W-1:0] peak,
  output logic                         height_valid
);

  localparam int MAG_W   = SAMPLE_W - 1;
  localparam int ACC_W   = MAG_W + AVG_LOG2;
  localparam int HOLD_W  = $clog2(HOLD_CNT + 2);
  localparam int DECAY_W = $clog2(DECAY_CNT + 2);

  localparam logic [MAG_W-1:0]   OFFSET_V = MAG_W'(OFFSET);
  localparam logic [MAG_W-1:0]   HMAX_V   = MAG_W'((1 << HEIGHT_W) - 1);
  localparam logic [HOLD_W-1:0]  HOLD_V   = HOLD_W'(HOLD_CNT);
  localparam logic [DECAY_W-1:0] DECAY_V  = DECAY_W'(DECAY_CNT);

  // Two's-complement magnitude; the most negative code saturates to full scale.
  function automatic logic [MAG_W-1:0] abs_sat(input logic [SAMPLE_W-1:0] s);
    logic [SAMPLE_W-1:0] neg;
    neg = ~s + {{(SAMPLE_W-1){1'b0}}, 1'b1};
    if (!s[SAMPLE_W-1]) begin
      abs_sat = s[MAG_W-1:0];
    end else if (neg[SAMPLE_W-1]) begin
      abs_sat = {MAG_W{1'b1}};
    end else begin
      abs_sat = neg[MAG_W-1:0];
    end
  endfunction

  function automatic logic [HEIGHT_W-1:0] to_height(input logic [MAG_W-1:0] v);
    logic [MAG_W-1:0] lvl;
    if (v > OFFSET_V) begin
      lvl = v - OFFSET_V;
    end else begin
      lvl = '0;
    end
    if (lvl > HMAX_V) begin
      to_height = HMAX_V[HEIGHT_W-1:0];
    end else begin
      to_height = lvl[HEIGHT_W-1:0];
    end
  endfunction

  logic                mode_prev_r;
  logic [AVG_LOG2-1:0] blk_cnt_r;
  logic                v1_r;
  logic                hv_r;
  logic                mode_chg_s;
  logic [AVG_LOG2-1:0] cnt_base_s;
  logic                blk_last_s;

  // A mode change restarts the block; a strobe in that cycle counts as its first sample.
  assign mode_chg_s   = (mode != mode_prev_r);
  assign cnt_base_s   = mode_chg_s ? '0 : blk_cnt_r;
  assign blk_last_s   = &cnt_base_s;
  assign height_valid = hv_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_prev_r <= 1'b0;
      blk_cnt_r   <= '0;
      v1_r        <= 1'b0;
      hv_r        <= 1'b0;
    end else begin
      mode_prev_r <= mode;
      v1_r        <= sample_valid & (~mode | blk_last_s);
      hv_r        <= v1_r;
      if (sample_valid && mode) begin
        blk_cnt_r <= cnt_base_s + AVG_LOG2'(1);
      end else if (mode_chg_s) begin
        blk_cnt_r <= '0;
      end else begin
        blk_cnt_r <= blk_cnt_r;
      end
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [MAG_W-1:0]    mag_s;
    logic [MAG_W-1:0]    scaled_s;
    logic [MAG_W-1:0]    avg_s;
    logic [MAG_W-1:0]    s1_r;
    logic [ACC_W-1:0]    acc_r;
    logic [ACC_W-1:0]    sum_s;
    logic [HEIGHT_W-1:0] h_new_s;
    logic [HEIGHT_W-1:0] cur_h_s;
    logic [HEIGHT_W-1:0] pk_dec_s;
    logic [HEIGHT_W-1:0] h_r;
    logic [HEIGHT_W-1:0] pk_r;
    logic [HOLD_W-1:0]   hold_r;
    logic [DECAY_W-1:0]  decay_r;

    assign mag_s    = abs_sat(sample_in[c*SAMPLE_W +: SAMPLE_W]);
    assign scaled_s = mag_s >> shift;
    assign sum_s    = (mode_chg_s ? '0 : acc_r) + {{AVG_LOG2{1'b0}}, scaled_s};
    assign avg_s    = sum_s[ACC_W-1:AVG_LOG2];
    assign h_new_s  = to_height(s1_r);
    assign cur_h_s  = v1_r ? h_new_s : h_r;
    assign pk_dec_s = (pk_r == '0) ? '0 : pk_r - HEIGHT_W'(1);

    assign height[c*HEIGHT_W +: HEIGHT_W] = h_r;
    assign peak[c*HEIGHT_W +: HEIGHT_W]   = pk_r;

    // Stage 1: scaled magnitude (mode 0) or block average (mode 1), plus the accumulator.
    always_ff @(posedge clk) begin
      if (rst) begin
        s1_r  <= '0;
        acc_r <= '0;
      end else begin
        if (sample_valid) begin
          s1_r <= mode ? avg_s : scaled_s;
        end else begin
          s1_r <= s1_r;
        end
        if (sample_valid && mode) begin
          acc_r <= blk_last_s ? '0 : sum_s;
        end else if (mode_chg_s) begin
          acc_r <= '0;
        end else begin
          acc_r <= acc_r;
        end
      end
    end

    // Stage 2: bar height, peak capture and strobe-timed hold/decay of the peak.
    always_ff @(posedge clk) begin
      if (rst) begin
        h_r     <= '0;
        pk_r    <= '0;
        hold_r  <= '0;
        decay_r <= '0;
      end else begin
        if (v1_r) begin
          h_r <= h_new_s;
        end else begin
          h_r <= h_r;
        end
        if (v1_r && (h_new_s >= pk_r)) begin
          pk_r    <= h_new_s;
          hold_r  <= HOLD_V;
          decay_r <= DECAY_V;
        end else if (sample_valid) begin
          if (hold_r != '0) begin
            hold_r <= hold_r - HOLD_W'(1);
          end else if (decay_r <= DECAY_W'(1)) begin
            pk_r    <= (pk_dec_s > cur_h_s) ? pk_dec_s : cur_h_s;
            decay_r <= DECAY_V;
          end else begin
            decay_r <= decay_r - DECAY_W'(1);
          end
        end else begin
          pk_r <= pk_r;
        end
      end
    end
  end

endmodule

// File: tb/tb_audio_level_meter.sv
// Self-checking bench for audio_level_meter: two instances (offset 0 and offset 3)
// share stimulus and are compared against a sample-level behavioural model.
module tb_audio_level_meter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_valid = 1'b0;
  logic        mode = 1'b0;
  logic [31:0] sample_in = '0;
  logic [3:0]  shift = '0;
  logic [7:0]  height_a, peak_a, height_b, peak_b;
  logic        hv_a, hv_b;
  logic [7:0]  got_h[2];
  logic [7:0]  got_p[2];
  logic        got_v[2];

  int n_checks = 0;
  int n_fail   = 0;

  int off_p[2]   = '{0, 3};
  int hold_p[2]  = '{4, 3};
  int decay_p[2] = '{2, 5};
  int m_h[2][2];
  int m_p[2][2];
  int m_hold[2][2];
  int m_dec[2][2];
  int blk_sum[2];
  int blk_n;
  bit m_mode;
  bit m_hv;

  always #5 clk = ~clk;

  audio_level_meter #(.CHANNELS(2), .SAMPLE_W(16), .HEIGHT_W(4), .OFFSET(0),
                      .AVG_LOG2(2), .HOLD_CNT(4), .DECAY_CNT(2)) dut_a (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_in(sample_in),
    .shift(shift), .mode(mode), .height(height_a), .peak(peak_a), .height_valid(hv_a));

  audio_level_meter #(.CHANNELS(2), .SAMPLE_W(16), .HEIGHT_W(4), .OFFSET(3),
                      .AVG_LOG2(2), .HOLD_CNT(3), .DECAY_CNT(5)) dut_b (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_in(sample_in),
    .shift(shift), .mode(mode), .height(height_b), .peak(peak_b), .height_valid(hv_b));

  assign got_h[0] = height_a;
  assign got_h[1] = height_b;
  assign got_p[0] = peak_a;
  assign got_p[1] = peak_b;
  assign got_v[0] = hv_a;
  assign got_v[1] = hv_b;

  function automatic int mag_of(logic [15:0] s);
    int v;
    v = $signed(s);
    if (v < 0) v = -v;
    if (v > 32767) v = 32767;
    return v;
  endfunction

  function automatic int level_of(int v, int off);
    int l;
    l = (v > off) ? v - off : 0;
    return (l > 15) ? 15 : l;
  endfunction

  function automatic logic [7:0] pack_h(int i);
    return {4'(m_h[i][1]), 4'(m_h[i][0])};
  endfunction

  function automatic logic [7:0] pack_p(int i);
    return {4'(m_p[i][1]), 4'(m_p[i][0])};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++)
      for (int c = 0; c < 2; c++) begin
        m_h[i][c] = 0; m_p[i][c] = 0; m_hold[i][c] = 0; m_dec[i][c] = 0;
      end
    blk_sum = '{0, 0};
    blk_n   = 0;
    m_hv    = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    sample_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // One strobe followed by two idle cycles; returns with the strobe's outputs visible.
  task automatic strobe(input logic [15:0] s0, input logic [15:0] s1, input int sh, input bit md);
    int  val[2];
    int  h;
    bit  out;
    @(negedge clk);
    sample_in = {s1, s0};
    shift = sh[3:0];
    mode = md;
    sample_valid = 1'b1;
    for (int i = 0; i < 2; i++)
      for (int c = 0; c < 2; c++) begin
        if (m_hold[i][c] > 0) begin
          m_hold[i][c]--;
        end else if (m_dec[i][c] <= 1) begin
          h = (m_p[i][c] > 0) ? m_p[i][c] - 1 : 0;
          m_p[i][c] = (h > m_h[i][c]) ? h : m_h[i][c];
          m_dec[i][c] = decay_p[i];
        end else begin
          m_dec[i][c]--;
        end
      end
    if (md != m_mode) begin
      blk_sum = '{0, 0};
      blk_n = 0;
    end
    m_mode = md;
    val[0] = mag_of(s0) >> sh;
    val[1] = mag_of(s1) >> sh;
    out = 1'b0;
    if (!md) begin
      out = 1'b1;
    end else begin
      blk_sum[0] += val[0];
      blk_sum[1] += val[1];
      blk_n++;
      if (blk_n == 4) begin
        out = 1'b1;
        val[0] = blk_sum[0] / 4;
        val[1] = blk_sum[1] / 4;
        blk_sum = '{0, 0};
        blk_n = 0;
      end
    end
    @(negedge clk);
    sample_valid = 1'b0;
    @(negedge clk);
    m_hv = out;
    if (out)
      for (int i = 0; i < 2; i++)
        for (int c = 0; c < 2; c++) begin
          h = level_of(val[c], off_p[i]);
          m_h[i][c] = h;
          if (h >= m_p[i][c]) begin
            m_p[i][c] = h; m_hold[i][c] = hold_p[i]; m_dec[i][c] = decay_p[i];
          end
        end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (got_v[i] !== 1'b0 || got_h[i] !== 8'h00 || got_p[i] !== 8'h00) begin
        n_fail++;
        $display("FAIL reset[%0d]: got v=%b h=%h p=%h, want 0/00/00", i, got_v[i], got_h[i], got_p[i]);
      end
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_basic();
    logic [15:0] s0[3] = '{16'h4000, 16'h8000, 16'h8000};
    logic [15:0] s1[3] = '{16'hFC00, 16'h8000, 16'h8000};
    int          sh[3] = '{8, 11, 15};
    logic [7:0]  want_a[3] = '{8'h4F, 8'hFF, 8'h00};
    logic [7:0]  want_b[3] = '{8'h1F, 8'hCC, 8'h00};
    for (int k = 0; k < 3; k++) begin
      strobe(s0[k], s1[k], sh[k], 1'b0);
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if (got_v[i] !== m_hv || got_h[i] !== pack_h(i) || got_p[i] !== pack_p(i)) begin
          n_fail++;
          $display("FAIL basic[%0d/%0d]: got v=%b h=%h p=%h, want v=%b h=%h p=%h",
                   k, i, got_v[i], got_h[i], got_p[i], m_hv, pack_h(i), pack_p(i));
        end
      end
      n_checks++;
      if (height_a !== want_a[k] || height_b !== want_b[k]) begin
        n_fail++;
        $display("FAIL basic_const[%0d]: got %h/%h, want %h/%h", k, height_a, height_b, want_a[k], want_b[k]);
      end
      @(negedge clk);
      n_checks++;
      if (hv_a !== 1'b0 || hv_b !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_pulse[%0d]: height_valid=%b%b one cycle late, want 00", k, hv_b, hv_a);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] v;
    do_reset();
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      if (j >= 2 && j <= 4) begin
        n_checks++;
        if (hv_a !== 1'b1 || height_a !== {4'(j - 1), 4'(j - 1)} || hv_b !== 1'b1 || height_b !== 8'h00) begin
          n_fail++;
          $display("FAIL b2b[%0d]: got v=%b%b h=%h/%h, want v=11 h=%h/00",
                   j, hv_b, hv_a, height_a, height_b, {4'(j - 1), 4'(j - 1)});
        end
      end else if (j == 5) begin
        n_checks++;
        if (hv_a !== 1'b0 || hv_b !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_end: got v=%b%b, want 00", hv_b, hv_a);
        end
      end
      if (j < 3) begin
        v = 16'h0100 * 16'(j + 1);
        sample_in = {~v + 16'd1, v};
        shift = 4'd8;
        mode = 1'b0;
        sample_valid = 1'b1;
      end else begin
        sample_valid = 1'b0;
      end
    end
    do_reset();
  endtask

  task automatic test_offset();
    logic [15:0] s0[2] = '{16'd2, 16'd20};
    logic [15:0] s1[2] = '{16'd5, 16'hFFEC};
    logic [7:0]  want_b[2] = '{8'h20, 8'hFF};
    for (int k = 0; k < 2; k++) begin
      strobe(s0[k], s1[k], 0, 1'b0);
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if (got_v[i] !== m_hv || got_h[i] !== pack_h(i) || got_p[i] !== pack_p(i)) begin
          n_fail++;
          $display("FAIL offset[%0d/%0d]: got v=%b h=%h p=%h, want v=%b h=%h p=%h",
                   k, i, got_v[i], got_h[i], got_p[i], m_hv, pack_h(i), pack_p(i));
        end
      end
      n_checks++;
      if (height_b !== want_b[k]) begin
        n_fail++;
        $display("FAIL offset_const[%0d]: got %h, want %h", k, height_b, want_b[k]);
      end
    end
  endtask

  task automatic test_peak();
    int want;
    do_reset();
    strobe(16'd10, 16'd0, 0, 1'b0);
    for (int phase = 0; phase < 2; phase++) begin
      for (int k = 1; k <= ((phase == 0) ? 10 : 30); k++) begin
        strobe(16'd0, 16'd0, 0, 1'b0);
        want = (phase == 0) ? 10 : 12;
        if (k > 4) want = want - (k - 4) / 2;
        if (want < 0) want = 0;
        for (int i = 0; i < 2; i++) begin
          n_checks++;
          if (got_v[i] !== m_hv || got_h[i] !== pack_h(i) || got_p[i] !== pack_p(i)) begin
            n_fail++;
            $display("FAIL peak[%0d/%0d/%0d]: got v=%b h=%h p=%h, want v=%b h=%h p=%h",
                     phase, k, i, got_v[i], got_h[i], got_p[i], m_hv, pack_h(i), pack_p(i));
          end
        end
        n_checks++;
        if (peak_a !== {4'd0, 4'(want)}) begin
          n_fail++;
          $display("FAIL peak_const[%0d/%0d]: got %h, want %h", phase, k, peak_a, {4'd0, 4'(want)});
        end
      end
      if (phase == 0) begin
        strobe(16'd12, 16'd0, 0, 1'b0);
        n_checks++;
        if (peak_a !== 8'h0C) begin
          n_fail++;
          $display("FAIL peak_new: got %h, want 0c", peak_a);
        end
      end
    end
  endtask

  task automatic test_average();
    logic [15:0] s0[4] = '{16'd4, 16'd8, 16'd12, 16'd0};
    logic [15:0] s1[4] = '{16'hFFFF, 16'hFFFE, 16'd3, 16'd10};
    for (int k = 0; k < 4; k++) begin
      strobe(s0[k], s1[k], 0, 1'b1);
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if (got_v[i] !== m_hv || got_h[i] !== pack_h(i) || got_p[i] !== pack_p(i)) begin
          n_fail++;
          $display("FAIL avg[%0d/%0d]: got v=%b h=%h p=%h, want v=%b h=%h p=%h",
                   k, i, got_v[i], got_h[i], got_p[i], m_hv, pack_h(i), pack_p(i));
        end
      end
    end
    n_checks++;
    if (hv_a !== 1'b1 || height_a !== 8'h46 || height_b !== 8'h13) begin
      n_fail++;
      $display("FAIL avg_const: got v=%b h=%h/%h, want 1 46/13", hv_a, height_a, height_b);
    end
  endtask

  task automatic test_mode_toggle();
    strobe(16'd40, 16'd40, 0, 1'b1);
    strobe(16'd40, 16'd40, 0, 1'b1);
    @(negedge clk);
    mode = 1'b0;
    @(negedge clk);
    mode = 1'b1;
    blk_sum = '{0, 0};
    blk_n = 0;
    for (int k = 0; k < 4; k++) begin
      strobe(16'd2, 16'd9, 0, 1'b1);
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if (got_v[i] !== m_hv || got_h[i] !== pack_h(i) || got_p[i] !== pack_p(i)) begin
          n_fail++;
          $display("FAIL toggle[%0d/%0d]: got v=%b h=%h p=%h, want v=%b h=%h p=%h",
                   k, i, got_v[i], got_h[i], got_p[i], m_hv, pack_h(i), pack_p(i));
        end
      end
      n_checks++;
      if (hv_a !== (k == 3)) begin
        n_fail++;
        $display("FAIL toggle_const[%0d]: got v=%b, want %b", k, hv_a, (k == 3));
      end
    end
  endtask

  task automatic test_reset_mid_block();
    strobe(16'd15, 16'd15, 0, 1'b1);
    strobe(16'd15, 16'd15, 0, 1'b1);
    do_reset();
    n_checks++;
    if (hv_a !== 1'b0 || height_a !== 8'h00 || peak_a !== 8'h00 || height_b !== 8'h00 || peak_b !== 8'h00) begin
      n_fail++;
      $display("FAIL midrst: got v=%b h=%h/%h p=%h/%h, want all 0", hv_a, height_a, height_b, peak_a, peak_b);
    end
    for (int k = 0; k < 4; k++) begin
      strobe(16'd8, 16'd16, 0, 1'b1);
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if (got_v[i] !== m_hv || got_h[i] !== pack_h(i) || got_p[i] !== pack_p(i)) begin
          n_fail++;
          $display("FAIL midrst[%0d/%0d]: got v=%b h=%h p=%h, want v=%b h=%h p=%h",
                   k, i, got_v[i], got_h[i], got_p[i], m_hv, pack_h(i), pack_p(i));
        end
      end
      n_checks++;
      if (hv_a !== (k == 3)) begin
        n_fail++;
        $display("FAIL midrst_const[%0d]: got v=%b, want %b", k, hv_a, (k == 3));
      end
    end
  endtask

  task automatic test_reset_inflight();
    @(negedge clk);
    sample_in = {16'h7000, 16'h7000};
    shift = 4'd0;
    mode = 1'b0;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    m_mode = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (hv_a !== 1'b0 || hv_b !== 1'b0 || height_a !== 8'h00 || height_b !== 8'h00) begin
        n_fail++;
        $display("FAIL inflight[%0d]: got v=%b%b h=%h/%h, want 00 00/00", k, hv_b, hv_a, height_a, height_b);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    logic [15:0] s0, s1;
    bit md;
    do_reset();
    md = m_mode;
    for (int k = 0; k < 60; k++) begin
      s0 = 16'($urandom);
      s1 = ($urandom_range(0, 9) == 0) ? 16'h8000 : 16'($urandom);
      if ($urandom_range(0, 7) == 0) md = ~md;
      strobe(s0, s1, $urandom_range(0, 12), md);
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if (got_v[i] !== m_hv || got_h[i] !== pack_h(i) || got_p[i] !== pack_p(i)) begin
          n_fail++;
          $display("FAIL random[%0d/%0d]: got v=%b h=%h p=%h, want v=%b h=%h p=%h",
                   k, i, got_v[i], got_h[i], got_p[i], m_hv, pack_h(i), pack_p(i));
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    m_mode = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_offset();
    test_peak();
    test_average();
    test_mode_toggle();
    test_reset_mid_block();
    test_reset_inflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
